// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } int_state_e;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_EOI  = 2'd2;
  localparam logic [1:0] REG_CUR  = 2'd3;

  localparam logic [3:0] INT_REGION = 4'hC;

  // CUR register layout: busy flag above the 4-bit source id.
  function automatic logic [31:0] cur_word(logic busy, logic [3:0] id);
    return {27'b0, busy, id};
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt sources.
module int_prio_enc #(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [3:0]      idx_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 4'd0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected sources, lowest-index arbitration, req/ack/EOI handshake.
// Define INT_SYNC_EN to pass each source through a 2-flop synchroniser before edge detect.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned NSRC     = 4,
  parameter int unsigned VEC_BASE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            wr,
  input  logic            rd,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            int_req,
  output logic [31:0]     int_num,
  input  logic            int_ack
);

  int_state_e      state_q;
  logic [NSRC-1:0] src_s, src_q, src_edge;
  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [NSRC-1:0] eligible, cur_onehot;
  logic [3:0]      cur_q, win_idx;
  logic            win_valid, cur_live;
  logic            bus_wr, mask_we, pend_we, eoi_we, ack_take;
  logic            unused_wdata;

`ifdef INT_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) src_q <= '0;
    else        src_q <= src_s;
  end

  assign src_edge = src_s & ~src_q;

  assign bus_wr       = sel & wr;
  assign mask_we      = bus_wr & (addr == REG_MASK);
  assign pend_we      = bus_wr & (addr == REG_PEND);
  assign eoi_we       = bus_wr & (addr == REG_EOI);
  assign ack_take     = (state_q == StReq) & int_ack;
  assign unused_wdata = ^wdata[31:NSRC];

  assign eligible   = pend_q & mask_q;
  assign cur_onehot = NSRC'(1) << cur_q;
  assign cur_live   = |(eligible & cur_onehot);

  // A new edge beats a same-cycle W1C or acknowledge on the same bit.
  always_comb begin
    pend_d = pend_q;
    if (pend_we)  pend_d = pend_d & ~wdata[NSRC-1:0];
    if (ack_take) pend_d = pend_d & ~cur_onehot;
    pend_d = pend_d | src_edge;
    mask_d = mask_we ? wdata[NSRC-1:0] : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  int_prio_enc #(
    .NSRC(NSRC)
  ) u_prio_enc (
    .req_i  (eligible),
    .valid_o(win_valid),
    .idx_o  (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      int_req <= 1'b0;
      int_num <= '0;
      cur_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q <= StReq;
            int_req <= 1'b1;
            int_num <= VEC_BASE + 32'(win_idx);
            cur_q   <= win_idx;
          end
        end
        StReq: begin
          if (int_ack) begin
            state_q <= StService;
            int_req <= 1'b0;
          end else if (!cur_live) begin
            // Withdrawn request leaves the vector bus idle, as after EOI.
            state_q <= StIdle;
            int_req <= 1'b0;
            int_num <= '0;
          end
        end
        StService: begin
          if (eoi_we) begin
            state_q <= StIdle;
            int_num <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel && rd) begin
      case (addr)
        REG_MASK: rdata[NSRC-1:0] = mask_q;
        REG_PEND: rdata[NSRC-1:0] = pend_q;
        REG_CUR:  rdata = cur_word(state_q == StService, cur_q);
        default:  rdata = '0;
      endcase
    end
  end

endmodule
